// File: rtl/lin_interpolator.sv
// ---------------------------------------------------------------------------
// lin_interpolator
//   Linear-interpolating upsampler feeding the DeltaSigma modulator. Accepts
//   low-rate signed samples over valid/ready and emits R = 2**LOG2R linearly
//   interpolated samples per input, one per clk.
//
// Parameters
//   DATA_W  sample width (two's complement), input and output
//   LOG2R   log2 of the interpolation ratio R (legal 1..6)
//   CNT_W   width of the saturating underrun counter
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high; clears all state
//   in_data       signed input sample
//   in_valid      in_data valid
//   in_ready      registered; transfer = in_valid & in_ready
//   out_data      signed interpolated sample (to DeltaSigma data_in)
//   out_valid     high every cycle once running; only reset drops it
//   underrun_cnt  saturating count of periods with no new sample available
//
// Configuration
//   INTERP_ROUND_EN  defined: output rounds half up; undefined: output
//                    truncates toward -inf.
// ---------------------------------------------------------------------------
module lin_interpolator #(
    parameter int DATA_W = 14,
    parameter int LOG2R  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         underrun_cnt
);

    localparam int ACC_W  = DATA_W + LOG2R + 1;
    localparam int DIFF_W = DATA_W + 1;
    localparam logic [LOG2R-1:0] PH_LAST = {LOG2R{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic signed [DATA_W-1:0]  buf_r, buf_s;
    logic                      buf_full_r, buf_full_s;
    logic                      in_ready_r;
    logic signed [DATA_W-1:0]  prev_r, prev_s;
    logic signed [DATA_W-1:0]  curr_r, curr_s;
    logic signed [DIFF_W-1:0]  diff_r, diff_s;
    logic signed [ACC_W-1:0]   acc_r, acc_s;
    logic [LOG2R-1:0]          phase_r, phase_s;
    logic signed [DATA_W-1:0]  out_data_r, out_data_s;
    logic                      out_valid_r, out_valid_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;

    logic                      transfer_s;
    logic                      consume_s;
    logic                      do_load_s;
    logic                      underrun_s;
    logic signed [ACC_W-1:0]   curr_scaled_s;
    logic signed [ACC_W-1:0]   acc_step_s;
    logic signed [ACC_W-1:0]   acc_out_s;
    logic signed [DATA_W-1:0]  interp_s;

    assign transfer_s    = in_valid & in_ready_r;
    // curr << LOG2R, sign-extended to the accumulator width
    assign curr_scaled_s = {curr_r[DATA_W-1], curr_r, {LOG2R{1'b0}}};
    assign acc_step_s    = acc_r + {{LOG2R{diff_r[DIFF_W-1]}}, diff_r};

`ifdef INTERP_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) <<< (LOG2R - 1);
    // Half an output LSB added before the shift gives round-half-up
    assign acc_out_s = acc_r + HALF_LSB;
`else
    assign acc_out_s = acc_r;
`endif

    // acc stays between prev<<LOG2R and curr<<LOG2R, so dropping the top bits is lossless
    assign interp_s = DATA_W'(acc_out_s >>> LOG2R);

    // Buffer occupancy: a transfer can only happen while empty, a consume only while full
    assign buf_full_s = transfer_s ? 1'b1 : (consume_s ? 1'b0 : buf_full_r);
    assign buf_s      = transfer_s ? in_data : buf_r;

    // Next-state and datapath update for the interpolation FSM
    always_comb begin
        state_s     = state_r;
        prev_s      = prev_r;
        curr_s      = curr_r;
        diff_s      = diff_r;
        acc_s       = acc_r;
        phase_s     = phase_r;
        out_data_s  = out_data_r;
        out_valid_s = out_valid_r;
        cnt_s       = cnt_r;
        consume_s   = 1'b0;
        do_load_s   = 1'b0;
        underrun_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (buf_full_r) begin
                    curr_s    = buf_r;
                    consume_s = 1'b1;
                    state_s   = ST_PRIME;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (buf_full_r) begin
                    do_load_s = 1'b1;
                    state_s   = ST_RUN;
                end else begin
                    state_s   = ST_PRIME;
                end
            end
            ST_RUN: begin
                out_data_s  = interp_s;
                out_valid_s = 1'b1;
                acc_s       = acc_step_s;
                phase_s     = phase_r + LOG2R'(1);
                if (phase_r == PH_LAST) begin
                    if (buf_full_r) begin
                        do_load_s  = 1'b1;
                    end else begin
                        underrun_s = 1'b1;
                    end
                end else begin
                    do_load_s  = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Segment boundary: start a new ramp, or hold curr when no sample is waiting
        case ({do_load_s, underrun_s})
            2'b10: begin
                prev_s    = curr_r;
                curr_s    = buf_r;
                diff_s    = {buf_r[DATA_W-1], buf_r} - {curr_r[DATA_W-1], curr_r};
                acc_s     = curr_scaled_s;
                phase_s   = {LOG2R{1'b0}};
                consume_s = 1'b1;
            end
            2'b01: begin
                prev_s  = curr_r;
                acc_s   = curr_scaled_s;
                diff_s  = {DIFF_W{1'b0}};
                phase_s = {LOG2R{1'b0}};
                if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            buf_r       <= {DATA_W{1'b0}};
            buf_full_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            prev_r      <= {DATA_W{1'b0}};
            curr_r      <= {DATA_W{1'b0}};
            diff_r      <= {DIFF_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            phase_r     <= {LOG2R{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            buf_r       <= buf_s;
            buf_full_r  <= buf_full_s;
            in_ready_r  <= ~buf_full_s;
            prev_r      <= prev_s;
            curr_r      <= curr_s;
            diff_r      <= diff_s;
            acc_r       <= acc_s;
            phase_r     <= phase_s;
            out_data_r  <= out_data_s;
            out_valid_r <= out_valid_s;
            cnt_r       <= cnt_s;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign underrun_cnt = cnt_r;

endmodule

// File: tb/tb_lin_interpolator.sv
// ---------------------------------------------------------------------------
// tb_lin_interpolator
//   Self-checking bench for lin_interpolator (DATA_W=14, LOG2R=2). A
//   behavioural model (one-entry queue for the buffer, closed-form
//   interpolation per output) predicts every output each cycle; directed
//   scenarios also compare output sequences against fixed values.
// ---------------------------------------------------------------------------
module tb_lin_interpolator;

    localparam int DATA_W  = 14;
    localparam int LOG2R   = 2;
    localparam int CNT_W   = 8;
    localparam int R       = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic [CNT_W-1:0]         underrun_cnt;

    always #5 clk = ~clk;

    lin_interpolator #(.DATA_W(DATA_W), .LOG2R(LOG2R), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .underrun_cnt(underrun_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Pending stimulus samples and observed valid outputs
    int src[$];
    int obs[$];

    // Reference model state
    int mq[$];
    bit m_rdy   = 1'b1;
    int m_stage = 0;   // 0 waiting first sample, 1 waiting second, 2 streaming
    int m_a     = 0;
    int m_b     = 0;
    int m_k     = 0;
    int m_out   = 0;
    bit m_valid = 1'b0;
    int m_cnt   = 0;
    bit m_took  = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int fdiv(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // k-th of R points on the line from a to b
    function automatic int interp(input int a, input int b, input int k);
        int num;
        num = a * R + k * (b - a);
`ifdef INTERP_ROUND_EN
        num = num + R / 2;
`endif
        return fdiv(num, R);
    endfunction

    task automatic model_step(input bit v, input int d, input bit r);
        if (r) begin
            mq.delete();
            m_rdy = 1'b1; m_stage = 0; m_a = 0; m_b = 0; m_k = 0;
            m_out = 0; m_valid = 1'b0; m_cnt = 0; m_took = 1'b0;
        end else begin
            m_took = v && m_rdy;
            case (m_stage)
                0: if (mq.size() > 0) begin
                    m_b = mq.pop_front();
                    m_stage = 1;
                end
                1: if (mq.size() > 0) begin
                    m_a = m_b;
                    m_b = mq.pop_front();
                    m_k = 0;
                    m_stage = 2;
                end
                default: begin
                    m_out   = interp(m_a, m_b, m_k);
                    m_valid = 1'b1;
                    if (m_k == R - 1) begin
                        m_a = m_b;
                        if (mq.size() > 0) m_b = mq.pop_front();
                        else if (m_cnt < CNT_SAT) m_cnt++;
                        m_k = 0;
                    end else begin
                        m_k++;
                    end
                end
            endcase
            if (m_took) mq.push_back(d);
            m_rdy = (mq.size() == 0);
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit r);
        in_valid = v;
        in_data  = d[DATA_W-1:0];
        reset    = r;
        @(posedge clk);
        model_step(v, d, r);
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_data", int'(out_data), m_out);
        chk("in_ready", int'(in_ready), int'(m_rdy));
        chk("underrun_cnt", int'(underrun_cnt), m_cnt);
        if (r) src.delete();
        else if (m_took) void'(src.pop_front());
        if (out_valid) obs.push_back(int'(out_data));
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            bit v;
            int d;
            v = (src.size() > 0) && ($urandom_range(99) < pct);
            d = v ? src[0] : (int'($urandom_range(16383)) - 8192);
            cycle(v, d, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b0, 0, 1'b1);
        obs.delete();
    endtask

    task automatic check_seq(input string tag, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            chk(tag, (i < obs.size()) ? obs[i] : -99999, exp[i]);
        end
    endtask

    initial begin
        int e[$];
        int guard;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;

        // Reset state
        do_reset(3);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_data", int'(out_data), 0);
        chk("rst_cnt", int'(underrun_cnt), 0);

        // Ramp then hold with periodic underruns
        src = {0, 400, 800};
        run(40, 100);
        e = {0, 100, 200, 300, 400, 500, 600, 700, 800, 800, 800, 800};
        check_seq("ramp", e);

        // Negative step, buffer kept fed
        do_reset(2);
        src = {-400, 400};
        for (int i = 0; i < 12; i++) src.push_back(int'($urandom_range(16383)) - 8192);
        run(40, 100);
        e = {-400, -200, 0, 200, 400};
        check_seq("neg_step", e);
        chk("fed_no_underrun", int'(underrun_cnt), 0);

        // Fractional step
        do_reset(2);
        src = {0, 3};
        run(20, 100);
`ifdef INTERP_ROUND_EN
        e = {0, 1, 2, 2, 3};
`else
        e = {0, 0, 1, 2, 3};
`endif
        check_seq("frac_step", e);

        // Full-scale step
        do_reset(2);
        src = {-8192, 8191};
        run(20, 100);
`ifdef INTERP_ROUND_EN
        e = {-8192, -4096, 0, 4095, 8191};
`else
        e = {-8192, -4097, -1, 4095, 8191};
`endif
        check_seq("full_scale", e);

        // Continuous in_valid with random data: backpressure
        do_reset(2);
        for (int i = 0; i < 20; i++) src.push_back(int'($urandom_range(16383)) - 8192);
        run(100, 100);

        // Reset mid-stream at phase 2, then the ramp must repeat exactly
        do_reset(2);
        src = {0, 400, 800};
        guard = 0;
        while (!(m_stage == 2 && m_k == 2) && guard < 40) begin
            run(1, 100);
            guard++;
        end
        chk("reach_phase2", int'(guard < 40), 1);
        cycle(1'b1, 0, 1'b0);
        cycle(1'b0, 0, 1'b1);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_data", int'(out_data), 0);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_cnt", int'(underrun_cnt), 0);
        obs.delete();
        src = {0, 400, 800};
        run(40, 100);
        e = {0, 100, 200, 300, 400, 500, 600, 700, 800, 800, 800, 800};
        check_seq("ramp_after_rst", e);

        // Random traffic with gaps and occasional resets
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            if (src.size() < 2) src.push_back(int'($urandom_range(16383)) - 8192);
            if ($urandom_range(249) == 0) cycle(1'b0, 0, 1'b1);
            else run(1, 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
